// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter and its sub-blocks.
// Contents:
//   AW, DW      - default address and data widths of the data memory
//   arb_state_e - arbiter FSM states (IDLE, OWN0, OWN1)
//   req_idx_t   - index of a requester (one bit for two requesters)
package dmem_arb_pkg;

    localparam int AW = 16;
    localparam int DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    typedef logic req_idx_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2
// Combinational two-way round-robin picker.
// Ports:
//   req_i  [1:0] in   request vector, bit i = requester i
//   last_i       in   index of the most recent winner
//   gnt_o  [1:0] out  one-hot grant; zero when nothing is requested
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // A lone requester always wins; on a tie the one that did not win last time goes.
    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between requester 0 (CPU load/store
// unit) and requester 1 (loader/debug port). One access per cycle, selected
// round-robin, with combinational grant and a registered read response.
// Optional locked ownership is built only when DMEM_ARB_LOCK_EN is defined;
// otherwise lock0/lock1 are ignored and the arbiter stays in IDLE.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN, weN, addrN, wdataN requester N access request
//   lockN                    keep the grant after this access
//   gntN                     combinational grant to requester N
//   rvalidN, rdataN          read response (one-cycle pulse, held data)
//   mem_we/addr/wdata        memory command; mem_rdata combinational read data
//   busy                     a grant is being issued this cycle
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW   = dmem_arb_pkg::AW,
    parameter int DW   = dmem_arb_pkg::DW,
    parameter int NREQ = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    arb_state_e    state_q, state_d;
    req_idx_t      last_q;
    logic [AW-1:0] addr_q;
    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    logic [NREQ-1:0] reqVec;
    logic [1:0]      pickGnt;
    logic [1:0]      gntVec;
    logic            anyGnt;
    logic            memWe;
    logic [AW-1:0]   memAddr;
    logic [DW-1:0]   memWdata;

    assign reqVec = {req1, req0};

    rr_pick2 uPick (
        .req_i  (reqVec),
        .last_i (last_q),
        .gnt_o  (pickGnt)
    );

`ifndef DMEM_ARB_LOCK_EN
    logic unusedLock;
    assign unusedLock = lock0 ^ lock1;
`endif

    // Grant selection: round-robin when idle, owner-only while locked.
    // Nothing is granted during reset so no access can slip through.
    always_comb begin
        gntVec = 2'b00;
        case (state_q)
            IDLE: gntVec = pickGnt;
`ifdef DMEM_ARB_LOCK_EN
            OWN0: gntVec = {1'b0, req0};
            OWN1: gntVec = {req1, 1'b0};
`endif
            default: gntVec = pickGnt;
        endcase
        if (rst) begin
            gntVec = 2'b00;
        end
    end

    assign anyGnt = |gntVec;

    // Memory command mux. With no grant the address holds its last value so
    // the memory's combinational read output does not toggle needlessly.
    always_comb begin
        memWe    = 1'b0;
        memAddr  = addr_q;
        memWdata = '0;
        if (gntVec[1]) begin
            memWe    = we1;
            memAddr  = addr1;
            memWdata = wdata1;
        end else if (gntVec[0]) begin
            memWe    = we0;
            memAddr  = addr0;
            memWdata = wdata0;
        end
    end

    // Next state: an accepted access sets or releases ownership from its lock bit.
    always_comb begin
        state_d = state_q;
`ifdef DMEM_ARB_LOCK_EN
        if (gntVec[0]) begin
            state_d = lock0 ? OWN0 : IDLE;
        end else if (gntVec[1]) begin
            state_d = lock1 ? OWN1 : IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            addr_q    <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            rvalid0_q <= gntVec[0] & ~we0;
            rvalid1_q <= gntVec[1] & ~we1;
            if (anyGnt) begin
                last_q <= gntVec[1];
                addr_q <= memAddr;
            end
            if (gntVec[0] && !we0) begin
                rdata0_q <= mem_rdata;
            end
            if (gntVec[1] && !we1) begin
                rdata1_q <= mem_rdata;
            end
        end
    end

    assign gnt0      = gntVec[0];
    assign gnt1      = gntVec[1];
    assign busy      = anyGnt;
    assign mem_we    = memWe & ~rst;
    assign mem_addr  = memAddr;
    assign mem_wdata = memWdata;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port 16-bit data memory between requester 0 (CPU load/store unit) and requester 1 (loader/debug port). It selects one requester per cycle by round-robin and drives the memory's write-enable, address and write-data. It captures the memory's combinational read data into a per-requester response register. It sits directly in front of `DataMemory`, and neither requester touches the memory directly.

## Interface
Parameters:
- `AW`, 16, address width
- `DW`, 16, data width
- `NREQ`, 2, number of requesters; fixed at 2 in this revision

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `req0`, `req1`  in  1  requester i asks for one access this cycle
- `we0`, `we1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  AW  access address
- `wdata0`, `wdata1`  in  DW  write data
- `lock0`, `lock1`  in  1  keep the grant after this access (see Configuration)
- `gnt0`, `gnt1`  out  1  combinational grant; access accepted when `reqi & gnti`
- `rvalid0`, `rvalid1`  out  1  read response valid, one-cycle pulse
- `rdata0`, `rdata1`  out  DW  registered read data, held until the next read response to that requester
- `mem_we`  out  1  to memory write enable, active-high
- `mem_addr`  out  AW  to memory address
- `mem_wdata`  out  DW  to memory write data
- `mem_rdata`  in  DW  from memory; combinational read of `mem_addr`
- `busy`  out  1  a grant is being issued this cycle

## Operation
- FSM states:
  - IDLE: no owner, round-robin selection each cycle.
  - OWN0 / OWN1: locked ownership, only with the macro.
- Round-robin pointer `last`, 1 bit, reset 1, so requester 0 wins the first tie.
  - Updated to the winner on every accepted access.
- Arbitration in IDLE:
  - Only one requester asserting `req`: that requester wins.
  - Both requesters asserting `req`: the winner is `~last`.
- `gnti` is asserted only when `reqi` is high. At most one grant per cycle.
- The memory port mirrors the winner's `we`/`addr`/`wdata`.
- With no grant:
  - `mem_we` = 0.
  - `mem_addr` holds its last driven value (register `addr_q`).
  - `mem_wdata` = 0.
- Write accept: memory writes at the closing edge and `rvalidi` stays 0.
- Read accept: `mem_rdata` is sampled at the closing edge into `rdatai`, and `rvalidi` = 1 for the next cycle.
- Back-to-back accesses to the same requester are allowed every cycle.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Reset values:
  - All `gnt`, `rvalid`, `mem_we` and `busy` outputs are 0.
  - `rdata0` and `rdata1` are 0.
  - `mem_addr` is 0 and `mem_wdata` is 0.
  - `last` is 1 and the FSM is in IDLE.
- `mem_we` is gated by `~rst`, so no write occurs in any reset cycle.
- Reset mid-lock drops ownership immediately, and a pending `rvalid` is cleared.

## Timing
- Grant latency: 0 cycles; grant is combinational from `req` and state.
- Write completes at the edge ending the grant cycle.
- Read data latency: 1 cycle, with `rvalidi` and `rdatai` valid in cycle N+1 for a read granted in cycle N.
- Requesters must hold `req`/`we`/`addr`/`wdata` stable until they see `gnt`. A dropped `req` without a grant is legal and has no effect.
- Fairness: under continuous requests from both requesters, with no lock, grants strictly alternate 0,1,0,1...
- Throughput: one access per cycle.

## Configuration
- `DMEM_ARB_LOCK_EN` defined:
  - An accepted access with `locki` = 1 moves the FSM to OWNi.
  - In OWNi only requester i can be granted, even when the other requester is requesting.
  - The first accepted access with `locki` = 0 returns the FSM to IDLE and updates `last` to i.
  - In OWNi, a cycle with `reqi` = 0 keeps ownership and grants nothing.
- `DMEM_ARB_LOCK_EN` undefined:
  - The `lock0`/`lock1` ports exist but are ignored.
  - The OWN states are not built, and the FSM stays in IDLE.

## Structure
- Package `dmem_arb_pkg`:
  - `AW` and `DW` constants.
  - FSM state enum with IDLE, OWN0 and OWN1.
  - Requester index typedef.
- Sub-module `rr_pick2`: combinational two-way round-robin picker (inputs `req[1:0]` and `last`; outputs a one-hot grant). It is reused by later multi-master blocks.
- Top level holds the FSM, the pointer, the address register and the response registers.

## Test plan
- Reset, then hold `rst` = 1 with `req0` = 1 and `we0` = 1 → `mem_we` = 0 and `gnt0` = 0. After release, every output matches its reset value.
- `req0` write: `addr0` = 3, `wdata0` = 16'h00AA. The next cycle is a `req0` read of address 3 → `rvalid0` = 1 one cycle later and `rdata0` = 16'h00AA.
- `req0` and `req1` both held for 6 cycles, all reads → grant sequence 0,1,0,1,0,1. `rvalid` follows one cycle behind each grant.
- Simultaneous requests: writes of addr 1/2 with data 16'h0001/16'h0002, then reads of both → each requester reads back its own data with no cross-talk.
- With `DMEM_ARB_LOCK_EN`: `req1` with `lock1` = 1 for 3 accesses while `req0` is held high → `gnt1`×3, then `lock1` = 0 on the 4th access, then `gnt0` on the next cycle.
- `rst` asserted in OWN1 → next cycle the FSM is IDLE, `rvalid1` = 0, and a pending `req0` is granted on the first cycle after release.
